// File: rtl/arriagx_pll_cfg_pkg.sv
// Shared types and constants for the Arria GX PLL counter configuration controller.
package arriagx_pll_cfg_pkg;

   // Apply-sequence states.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HOLD    = 2'd1,
      ST_UPDATE  = 2'd2,
      ST_RELEASE = 2'd3
   } cfg_state_e;

   // Field selector codes carried on cfg_field.
   localparam logic FLD_MODULUS = 1'b0;
   localparam logic FLD_INITIAL = 1'b1;

   // Value loaded into every modulus / initial-value register at reset.
   localparam int unsigned FIELD_DEFAULT = 1;

endpackage

// File: rtl/arriagx_pll_cntr_cfg_slot.sv
// One counter's configuration slot: shadow and active modulus/initial-value
// registers plus the dirty flag marking a pending shadow change.
module arriagx_pll_cntr_cfg_slot
   import arriagx_pll_cfg_pkg::*;
#(
   parameter int CW = 9
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          wr_en_i,
   input  logic          wr_field_i,
   input  logic [CW-1:0] wr_data_i,
   input  logic          commit_i,
   output logic [CW-1:0] modulus_o,
   output logic [CW-1:0] initial_o,
   output logic          dirty_o
);

   logic [CW-1:0] shadow_mod_q;
   logic [CW-1:0] shadow_init_q;
   logic [CW-1:0] active_mod_q;
   logic [CW-1:0] active_init_q;
   logic          dirty_q;

   // Shadow writes mark the slot dirty; a commit copies shadow to active and cleans it.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         shadow_mod_q  <= CW'(FIELD_DEFAULT);
         shadow_init_q <= CW'(FIELD_DEFAULT);
         active_mod_q  <= CW'(FIELD_DEFAULT);
         active_init_q <= CW'(FIELD_DEFAULT);
         dirty_q       <= 1'b0;
      end else if (wr_en_i) begin
         if (wr_field_i == FLD_MODULUS) begin
            shadow_mod_q <= wr_data_i;
         end else begin
            shadow_init_q <= wr_data_i;
         end
         dirty_q <= 1'b1;
      end else if (commit_i) begin
         active_mod_q  <= shadow_mod_q;
         active_init_q <= shadow_init_q;
         dirty_q       <= 1'b0;
      end
   end

   assign modulus_o = active_mod_q;
   assign initial_o = active_init_q;
   assign dirty_o   = dirty_q;

endmodule

// File: rtl/arriagx_pll_cntr_cfg_ctrl.sv
// Runtime configuration controller for a bank of PLL counters. Writes land in
// per-counter shadow registers; an apply holds the changed counters in reset,
// commits shadow to active in one cycle, then releases them together.
module arriagx_pll_cntr_cfg_ctrl
   import arriagx_pll_cfg_pkg::*;
#(
   parameter int N_CNTR     = 4,
   parameter int CW         = 9,
   parameter int RST_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [$clog2(N_CNTR):0] cfg_sel,
   input  logic                   cfg_field,
   input  logic [CW-1:0]          cfg_data,
   output logic                   cfg_err,
   input  logic                   apply,
   output logic                   busy,
   output logic                   done,
   output logic [N_CNTR-1:0]      cntr_reset,
   output logic [N_CNTR*CW-1:0]   modulus,
   output logic [N_CNTR*CW-1:0]   initial_value
);

   // One extra select bit so out-of-range counter indices are representable and rejected.
   localparam int SEL_W = $clog2(N_CNTR) + 1;
   localparam logic [SEL_W-1:0] SEL_LIMIT = SEL_W'(N_CNTR);
   localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   cfg_state_e        state_q;
   logic [HW-1:0]     hold_cnt_q;
   logic [N_CNTR-1:0] upd_mask_q;
   logic [N_CNTR-1:0] cntr_reset_q;
   logic              cfg_ready_q;
   logic              cfg_err_q;
   logic              busy_q;
   logic              done_q;

   logic              wr_fire_s;
   logic              wr_bad_s;
   logic [N_CNTR-1:0] wr_en_s;
   logic [N_CNTR-1:0] dirty_s;
   logic [N_CNTR-1:0] pend_s;
   logic [N_CNTR-1:0] commit_s;

   // Handshake, validation and the per-slot write/commit strobes.
   always_comb begin
      wr_fire_s = cfg_valid & cfg_ready_q;
      wr_bad_s  = (cfg_data == '0) || (cfg_sel >= SEL_LIMIT);
      wr_en_s   = '0;
      for (int i = 0; i < N_CNTR; i++) begin
         wr_en_s[i] = wr_fire_s & ~wr_bad_s & (cfg_sel == SEL_W'(i));
      end
      // A write accepted alongside apply joins that apply's update set.
      pend_s = dirty_s | wr_en_s;
      if (state_q == ST_UPDATE) begin
         commit_s = upd_mask_q;
      end else begin
         commit_s = '0;
      end
   end

   // Apply sequencer with registered handshake, status and counter-reset outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         hold_cnt_q   <= '0;
         upd_mask_q   <= '0;
         cntr_reset_q <= '1;
         cfg_ready_q  <= 1'b0;
         cfg_err_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         cfg_err_q <= wr_fire_s & wr_bad_s;
         done_q    <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               cntr_reset_q <= '0;
               cfg_ready_q  <= 1'b1;
               busy_q       <= 1'b0;
               if (apply) begin
                  if (|pend_s) begin
                     state_q      <= ST_HOLD;
                     upd_mask_q   <= pend_s;
                     cntr_reset_q <= pend_s;
                     hold_cnt_q   <= HW'(RST_CYCLES - 1);
                     cfg_ready_q  <= 1'b0;
                     busy_q       <= 1'b1;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               if (hold_cnt_q == '0) begin
                  state_q <= ST_UPDATE;
               end else begin
                  hold_cnt_q <= hold_cnt_q - HW'(1);
               end
            end
            ST_UPDATE: begin
               // Active registers load at this edge, so values and done appear together.
               state_q      <= ST_RELEASE;
               cntr_reset_q <= '0;
               done_q       <= 1'b1;
            end
            ST_RELEASE: begin
               state_q     <= ST_IDLE;
               upd_mask_q  <= '0;
               cfg_ready_q <= 1'b1;
               busy_q      <= 1'b0;
            end
            default: begin
               state_q      <= ST_IDLE;
               upd_mask_q   <= '0;
               cntr_reset_q <= '0;
               cfg_ready_q  <= 1'b0;
               busy_q       <= 1'b0;
            end
         endcase
      end
   end

   for (genvar g = 0; g < N_CNTR; g++) begin : g_slot
      arriagx_pll_cntr_cfg_slot #(
         .CW(CW)
      ) u_slot (
         .clk_i      (clk),
         .reset_i    (reset),
         .wr_en_i    (wr_en_s[g]),
         .wr_field_i (cfg_field),
         .wr_data_i  (cfg_data),
         .commit_i   (commit_s[g]),
         .modulus_o  (modulus[g*CW +: CW]),
         .initial_o  (initial_value[g*CW +: CW]),
         .dirty_o    (dirty_s[g])
      );
   end

   assign cfg_ready  = cfg_ready_q;
   assign cfg_err    = cfg_err_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign cntr_reset = cntr_reset_q;

endmodule

// File: tb/tb_arriagx_pll_cntr_cfg_ctrl.sv
// Randomized self-checking bench for arriagx_pll_cntr_cfg_ctrl against a
// behavioural shadow/active bank model.
module tb_arriagx_pll_cntr_cfg_ctrl;

   localparam int N   = 4;
   localparam int CW  = 9;
   localparam int RST = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic            cfg_valid;
   logic            cfg_ready;
   logic [2:0]      cfg_sel;
   logic            cfg_field;
   logic [CW-1:0]   cfg_data;
   logic            cfg_err;
   logic            apply;
   logic            busy;
   logic            done;
   logic [N-1:0]    cntr_reset;
   logic [N*CW-1:0] modulus;
   logic [N*CW-1:0] initial_value;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: shadow/active values per counter and field, plus dirty set.
   logic [CW-1:0] sh [N][2];
   logic [CW-1:0] ac [N][2];
   logic [N-1:0]  dm;

   arriagx_pll_cntr_cfg_ctrl #(.N_CNTR(N), .CW(CW), .RST_CYCLES(RST)) dut (
      .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_sel(cfg_sel), .cfg_field(cfg_field), .cfg_data(cfg_data),
      .cfg_err(cfg_err), .apply(apply), .busy(busy), .done(done),
      .cntr_reset(cntr_reset), .modulus(modulus), .initial_value(initial_value)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         for (int f = 0; f < 2; f++) begin
            sh[i][f] = 9'd1;
            ac[i][f] = 9'd1;
         end
      end
      dm = '0;
   endfunction

   // Returns 1 when the write is legal and applied to the shadow bank.
   function automatic bit model_write(input int sel, input int fld, input logic [CW-1:0] data);
      if (data == 9'd0 || sel >= N) return 1'b0;
      sh[sel][fld] = data;
      dm[sel] = 1'b1;
      return 1'b1;
   endfunction

   // Commits dirty counters and returns the set that was updated.
   function automatic logic [N-1:0] model_apply();
      logic [N-1:0] m;
      m = dm;
      for (int i = 0; i < N; i++) begin
         if (m[i]) begin
            ac[i][0] = sh[i][0];
            ac[i][1] = sh[i][1];
         end
      end
      dm = '0;
      return m;
   endfunction

   function automatic logic [N*CW-1:0] exp_vec(input int fld);
      logic [N*CW-1:0] v;
      for (int i = 0; i < N; i++) v[i*CW +: CW] = ac[i][fld];
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One-cycle write; returns cfg_ready during the request and cfg_err the cycle after.
   task automatic do_write(input int sel, input int fld, input logic [CW-1:0] data,
                           output logic rdy, output logic err);
      rdy       = cfg_ready;
      cfg_valid = 1'b1;
      cfg_sel   = 3'(sel);
      cfg_field = fld[0];
      cfg_data  = data;
      step();
      cfg_valid = 1'b0;
      err       = cfg_err;
   endtask

   // Pulses apply (optionally with a write) and observes until the bank returns to idle.
   task automatic run_apply(input bit with_wr, input int sel, input int fld, input logic [CW-1:0] data,
                            output int done_at, output int done_cnt, output int rst_cnt,
                            output logic [N-1:0] rst_pat, output bit idle_ok);
      apply     = 1'b1;
      cfg_valid = with_wr;
      cfg_sel   = 3'(sel);
      cfg_field = fld[0];
      cfg_data  = data;
      done_at = -1; done_cnt = 0; rst_cnt = 0; rst_pat = '0; idle_ok = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         step();
         apply     = 1'b0;
         cfg_valid = 1'b0;
         if (done) begin
            done_cnt++;
            if (done_at < 0) done_at = k;
         end
         if (cntr_reset != '0) begin
            rst_cnt++;
            rst_pat |= cntr_reset;
         end
         if (cfg_ready && !busy) begin
            idle_ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; cfg_valid = 1'b0; apply = 1'b0;
      cfg_sel = '0; cfg_field = 1'b0; cfg_data = '0;
      step(); step();
      model_reset();
      n_checks++; if (cntr_reset !== 4'hF) $display("FAIL reset_cntr_reset got %b exp %b", cntr_reset, 4'hF); else n_pass++;
      n_checks++; if ({cfg_ready, busy, done, cfg_err} !== 4'b0000) $display("FAIL reset_status got %b exp 0000", {cfg_ready, busy, done, cfg_err}); else n_pass++;
      n_checks++; if (modulus !== exp_vec(0) || initial_value !== exp_vec(1)) $display("FAIL reset_values got %h/%h exp %h/%h", modulus, initial_value, exp_vec(0), exp_vec(1)); else n_pass++;
      reset = 1'b0;
      step();
      n_checks++; if (cntr_reset !== 4'h0 || cfg_ready !== 1'b1) $display("FAIL reset_release got rst=%b rdy=%b exp 0000/1", cntr_reset, cfg_ready); else n_pass++;
   endtask

   task automatic test_single_apply();
      logic rdy, err; int da, dc, rc; logic [N-1:0] rp, em; bit ok;
      do_write(2, 0, 9'd5, rdy, err); void'(model_write(2, 0, 9'd5));
      n_checks++; if (rdy !== 1'b1 || err !== 1'b0) $display("FAIL single_wr_mod got rdy=%b err=%b exp 1/0", rdy, err); else n_pass++;
      do_write(2, 1, 9'd3, rdy, err); void'(model_write(2, 1, 9'd3));
      n_checks++; if (err !== 1'b0) $display("FAIL single_wr_init got err=%b exp 0", err); else n_pass++;
      run_apply(1'b0, 0, 0, '0, da, dc, rc, rp, ok);
      em = model_apply();
      n_checks++; if (rp !== 4'b0100 || rp !== em || rc != RST + 1) $display("FAIL single_cntr_reset got %b x%0d exp %b x%0d", rp, rc, em, RST + 1); else n_pass++;
      n_checks++; if (da != RST + 2 || dc != 1 || !ok) $display("FAIL single_done got at=%0d cnt=%0d idle=%0d exp at=%0d cnt=1", da, dc, ok, RST + 2); else n_pass++;
      n_checks++; if (modulus[2*CW +: CW] !== 9'd5 || initial_value[2*CW +: CW] !== 9'd3) $display("FAIL single_cntr2 got %0d/%0d exp 5/3", modulus[2*CW +: CW], initial_value[2*CW +: CW]); else n_pass++;
      n_checks++; if (modulus !== exp_vec(0) || initial_value !== exp_vec(1)) $display("FAIL single_bank got %h/%h exp %h/%h", modulus, initial_value, exp_vec(0), exp_vec(1)); else n_pass++;
   endtask

   task automatic test_reject();
      logic rdy, err; int da, dc, rc; logic [N-1:0] rp; bit ok;
      do_write(1, 0, 9'd0, rdy, err);
      n_checks++; if (err !== 1'b1) $display("FAIL reject_zero got err=%b exp 1", err); else n_pass++;
      step();
      n_checks++; if (cfg_err !== 1'b0) $display("FAIL reject_pulse_width got err=%b exp 0", cfg_err); else n_pass++;
      do_write(5, 1, 9'd7, rdy, err);
      n_checks++; if (err !== 1'b1) $display("FAIL reject_sel got err=%b exp 1", err); else n_pass++;
      step();
      n_checks++; if (cfg_err !== 1'b0) $display("FAIL reject_sel_pulse got err=%b exp 0", cfg_err); else n_pass++;
      run_apply(1'b0, 0, 0, '0, da, dc, rc, rp, ok);
      n_checks++; if (da != 1 || dc != 1 || rc != 0) $display("FAIL reject_apply got at=%0d cnt=%0d rst=%0d exp 1/1/0", da, dc, rc); else n_pass++;
      n_checks++; if (modulus !== exp_vec(0) || initial_value !== exp_vec(1)) $display("FAIL reject_bank got %h/%h exp %h/%h", modulus, initial_value, exp_vec(0), exp_vec(1)); else n_pass++;
   endtask

   task automatic test_write_with_apply();
      int da, dc, rc; logic [N-1:0] rp, em; bit ok;
      run_apply(1'b1, 0, 0, 9'd7, da, dc, rc, rp, ok);
      void'(model_write(0, 0, 9'd7));
      em = model_apply();
      n_checks++; if (rp !== em || da != RST + 2) $display("FAIL wr_apply_seq got mask=%b at=%0d exp %b/%0d", rp, da, em, RST + 2); else n_pass++;
      n_checks++; if (modulus[CW-1:0] !== 9'd7 || modulus !== exp_vec(0)) $display("FAIL wr_apply_value got %h exp %h", modulus, exp_vec(0)); else n_pass++;
   endtask

   task automatic test_apply_during_hold();
      logic rdy, err; int dcnt; bit seen_err, idle; int da, dc, rc; logic [N-1:0] rp, em;
      do_write(1, 1, 9'd4, rdy, err); void'(model_write(1, 1, 9'd4));
      apply = 1'b1;
      step();
      n_checks++; if (busy !== 1'b1 || cfg_ready !== 1'b0) $display("FAIL hold_state got busy=%b rdy=%b exp 1/0", busy, cfg_ready); else n_pass++;
      cfg_valid = 1'b1; cfg_sel = 3'd0; cfg_field = 1'b0; cfg_data = 9'd9;
      dcnt = 0; seen_err = 1'b0; idle = 1'b0;
      for (int k = 0; k < 12; k++) begin
         step();
         apply = 1'b0; cfg_valid = 1'b0;
         if (done) dcnt++;
         if (cfg_err) seen_err = 1'b1;
         if (cfg_ready && !busy) idle = 1'b1;
      end
      em = model_apply();
      n_checks++; if (dcnt != 1 || seen_err || !idle) $display("FAIL hold_ignore got done=%0d err=%0d idle=%0d exp 1/0/1", dcnt, seen_err, idle); else n_pass++;
      n_checks++; if (modulus !== exp_vec(0) || initial_value !== exp_vec(1)) $display("FAIL hold_bank got %h/%h exp %h/%h", modulus, initial_value, exp_vec(0), exp_vec(1)); else n_pass++;
      run_apply(1'b0, 0, 0, '0, da, dc, rc, rp, idle);
      n_checks++; if (da != 1 || rc != 0) $display("FAIL hold_no_dirty got at=%0d rst=%0d exp 1/0", da, rc); else n_pass++;
   endtask

   task automatic test_reset_during_update();
      logic rdy, err; int da, dc, rc; logic [N-1:0] rp; bit ok;
      do_write(3, 0, 9'd11, rdy, err);
      apply = 1'b1;
      step(); apply = 1'b0;
      step(); step();
      n_checks++; if (cntr_reset !== 4'b1000 || busy !== 1'b1) $display("FAIL upd_state got rst=%b busy=%b exp 1000/1", cntr_reset, busy); else n_pass++;
      reset = 1'b1;
      step();
      model_reset();
      n_checks++; if (done !== 1'b0 || busy !== 1'b0 || cntr_reset !== 4'hF) $display("FAIL upd_abort got done=%b busy=%b rst=%b exp 0/0/1111", done, busy, cntr_reset); else n_pass++;
      n_checks++; if (modulus !== exp_vec(0) || initial_value !== exp_vec(1)) $display("FAIL upd_abort_bank got %h/%h exp %h/%h", modulus, initial_value, exp_vec(0), exp_vec(1)); else n_pass++;
      reset = 1'b0;
      step();
      n_checks++; if (cntr_reset !== 4'h0 || cfg_ready !== 1'b1 || done !== 1'b0) $display("FAIL upd_release got rst=%b rdy=%b done=%b exp 0000/1/0", cntr_reset, cfg_ready, done); else n_pass++;
      run_apply(1'b0, 0, 0, '0, da, dc, rc, rp, ok);
      n_checks++; if (da != 1 || rc != 0) $display("FAIL upd_shadow_discard got at=%0d rst=%0d exp 1/0", da, rc); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic rdy, err; int da, dc, rc; logic [N-1:0] rp, em; bit ok; logic [CW-1:0] d;
      d = 9'($urandom_range(1, 511));
      do_write(0, 0, d, rdy, err); void'(model_write(0, 0, d));
      run_apply(1'b0, 0, 0, '0, da, dc, rc, rp, ok);
      em = model_apply();
      n_checks++; if (rp !== em) $display("FAIL b2b_first got %b exp %b", rp, em); else n_pass++;
      d = 9'($urandom_range(1, 511));
      do_write(1, 0, d, rdy, err); void'(model_write(1, 0, d));
      d = 9'($urandom_range(1, 511));
      do_write(3, 1, d, rdy, err); void'(model_write(3, 1, d));
      run_apply(1'b0, 0, 0, '0, da, dc, rc, rp, ok);
      em = model_apply();
      n_checks++; if (rp !== 4'b1010 || rp !== em || da != RST + 2) $display("FAIL b2b_second got %b at=%0d exp %b at=%0d", rp, da, em, RST + 2); else n_pass++;
      n_checks++; if (modulus !== exp_vec(0) || initial_value !== exp_vec(1)) $display("FAIL b2b_bank got %h/%h exp %h/%h", modulus, initial_value, exp_vec(0), exp_vec(1)); else n_pass++;
   endtask

   task automatic test_random();
      logic rdy, err; int da, dc, rc; logic [N-1:0] rp, em; bit ok, exp_ok, wr;
      int sel, fld; logic [CW-1:0] d;
      for (int it = 0; it < 40; it++) begin
         sel = $urandom_range(0, 5);
         fld = $urandom_range(0, 1);
         d   = ($urandom_range(0, 4) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
         if ($urandom_range(0, 3) != 0) begin
            do_write(sel, fld, d, rdy, err);
            exp_ok = model_write(sel, fld, d);
            n_checks++; if (err !== !exp_ok) $display("FAIL rnd_write it=%0d got err=%b exp %b", it, err, !exp_ok); else n_pass++;
         end else begin
            wr = $urandom_range(0, 1);
            run_apply(wr, sel, fld, d, da, dc, rc, rp, ok);
            if (wr) void'(model_write(sel, fld, d));
            em = model_apply();
            n_checks++;
            if (rp !== em || da != ((em != '0) ? RST + 2 : 1) || rc != ((em != '0) ? RST + 1 : 0) || dc != 1 || !ok)
               $display("FAIL rnd_apply it=%0d got mask=%b at=%0d rst=%0d done=%0d exp mask=%b", it, rp, da, rc, dc, em);
            else n_pass++;
            n_checks++; if (modulus !== exp_vec(0) || initial_value !== exp_vec(1)) $display("FAIL rnd_bank it=%0d got %h/%h exp %h/%h", it, modulus, initial_value, exp_vec(0), exp_vec(1)); else n_pass++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_apply();
      test_reject();
      test_write_with_apply();
      test_apply_during_hold();
      test_reset_during_update();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
